// File: rtl/seg7_pkg.sv
// Shared types, constants and the segment decoder for the 7-segment output stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package seg7_pkg;

  // Conversion sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // Digit code: 0..15 are hex/decimal glyphs, above that are special glyphs
  typedef logic [4:0] digit_t;

  localparam digit_t DIG_BLANK = 5'd16;
  localparam digit_t DIG_DASH  = 5'd17;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Largest value that fits on four decimal digits
  localparam logic [15:0] DEC_MAX = 16'd9999;

  function automatic logic [6:0] seg_decode(input digit_t d);
    logic [6:0] s;
    case (d)
      5'd0:    s = 7'h40;
      5'd1:    s = 7'h79;
      5'd2:    s = 7'h24;
      5'd3:    s = 7'h30;
      5'd4:    s = 7'h19;
      5'd5:    s = 7'h12;
      5'd6:    s = 7'h02;
      5'd7:    s = 7'h78;
      5'd8:    s = 7'h00;
      5'd9:    s = 7'h10;
      5'd10:   s = 7'h08;
      5'd11:   s = 7'h03;
      5'd12:   s = 7'h46;
      5'd13:   s = 7'h21;
      5'd14:   s = 7'h06;
      5'd15:   s = 7'h0E;
      DIG_DASH: s = SEG_DASH;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin16_to_bcd.sv
// Sequential double-dabble: 16-bit binary to four BCD nibbles, one bit per cycle.
// Latency: start cycle loads, then 16 shift cycles; done is high during the last shift.
// Backpressure: start is ignored while busy; result holds in bcd until the next start.
module bin16_to_bcd (
  input  logic        clk,
  input  logic        btnC,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd
);

  // {bcd[15:0], bin[15:0]} working register
  logic [31:0] sr_q, sr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        run_q, run_d;
  logic [31:0] adj;

  // Add-3 correction on the BCD half, then shift the whole register left
  always_comb begin
    adj   = sr_q;
    sr_d  = sr_q;
    cnt_d = cnt_q;
    run_d = run_q;
    for (int i = 0; i < 4; i++) begin
      if (sr_q[16+4*i +: 4] >= 4'd5) begin
        adj[16+4*i +: 4] = sr_q[16+4*i +: 4] + 4'd3;
      end
    end
    if (run_q) begin
      sr_d  = {adj[30:0], 1'b0};
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == 4'd15) begin
        run_d = 1'b0;
      end
    end else if (start) begin
      sr_d  = {16'h0000, bin};
      cnt_d = 4'd0;
      run_d = 1'b1;
    end
  end

  // Engine state registers
  always_ff @(posedge clk) begin
    if (btnC) begin
      sr_q  <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign busy = run_q;
  assign done = run_q && (cnt_q == 4'd15);
  assign bcd  = sr_q[31:16];

endmodule

// File: rtl/seg7_scan_display.sv
// Shows a 16-bit value on a 4-digit common-anode display, decimal (with blanking/overflow) or hex.
// Latency: input change to digit registers <= 18 cycles; digit reaches seg on its next scan slot.
// Backpressure: none; input changes during a conversion are picked up after it commits.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = $clog2(REFRESH_DIV)
) (
  input  logic        clk,
  input  logic        btnC,
  input  logic [15:0] value,
  input  logic        hex_mode,
  output logic [6:0]  seg,
  output logic [3:0]  anode,
  output logic        dp,
  output logic        busy
);

  state_e           state_q, state_d;
  logic [15:0]      src_val_q, src_val_d;
  logic             src_hex_q, src_hex_d;
  logic             force_q, force_d;
  logic             busy_q, busy_d;
  digit_t [3:0]     digit_q, digit_d;
  digit_t [3:0]     commit_dig;
  logic [CNT_W-1:0] refresh_q, refresh_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       anode_q, anode_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  logic             src_change;
  logic             eng_start;
  logic             eng_busy;
  logic             eng_done;
  logic [15:0]      eng_bcd;
  logic             lead;

  bin16_to_bcd u_bcd (
    .clk   (clk),
    .btnC  (btnC),
    .start (eng_start),
    .bin   (value),
    .busy  (eng_busy),
    .done  (eng_done),
    .bcd   (eng_bcd)
  );

  assign src_change = force_q || (hex_mode != src_hex_q) || (value != src_val_q);

  // Build the digit set that a commit would write, from the latched source
  always_comb begin
    commit_dig = '0;
    lead       = 1'b1;
    if (src_hex_q) begin
      for (int k = 0; k < 4; k++) begin
        commit_dig[k] = {1'b0, src_val_q[4*k +: 4]};
      end
    end else if (src_val_q > DEC_MAX) begin
      for (int k = 0; k < 4; k++) begin
        commit_dig[k] = DIG_DASH;
      end
    end else begin
      for (int k = 3; k >= 1; k--) begin
        if (lead && (eng_bcd[4*k +: 4] == 4'd0)) begin
          commit_dig[k] = DIG_BLANK;
        end else begin
          commit_dig[k] = {1'b0, eng_bcd[4*k +: 4]};
          lead          = 1'b0;
        end
      end
      // The units digit always shows, so zero reads as "0"
      commit_dig[0] = {1'b0, eng_bcd[3:0]};
    end
  end

  // Change detect and conversion sequencing; digits only move in COMMIT
  always_comb begin
    state_d   = state_q;
    src_val_d = src_val_q;
    src_hex_d = src_hex_q;
    force_d   = force_q;
    digit_d   = digit_q;
    eng_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (src_change && !eng_busy) begin
          src_val_d = value;
          src_hex_d = hex_mode;
          force_d   = 1'b0;
          eng_start = 1'b1;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (eng_done) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        digit_d = commit_dig;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Free-running digit scan, independent of the conversion sequencer
  always_comb begin
    refresh_d = refresh_q + CNT_W'(1);
    idx_d     = idx_q;
    if (refresh_q == CNT_W'(REFRESH_DIV - 1)) begin
      refresh_d = '0;
      idx_d     = idx_q + 2'd1;
    end
    anode_d = ~(4'b0001 << idx_q);
    seg_d   = seg_decode(digit_q[idx_q]);
    dp_d    = 1'b1;
  end

  // All state and outputs registered with synchronous reset
  always_ff @(posedge clk) begin
    if (btnC) begin
      state_q   <= ST_IDLE;
      src_val_q <= '0;
      src_hex_q <= 1'b0;
      force_q   <= 1'b1;
      busy_q    <= 1'b0;
      digit_q   <= '0;
      refresh_q <= '0;
      idx_q     <= '0;
      anode_q   <= 4'hF;
      seg_q     <= SEG_BLANK;
      dp_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      src_val_q <= src_val_d;
      src_hex_q <= src_hex_d;
      force_q   <= force_d;
      busy_q    <= busy_d;
      digit_q   <= digit_d;
      refresh_q <= refresh_d;
      idx_q     <= idx_d;
      anode_q   <= anode_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign seg   = seg_q;
  assign anode = anode_q;
  assign dp    = dp_q;
  assign busy  = busy_q;

endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
- Output stage directly downstream of the switch-driven multiply-accumulate top level.
- Consumes the 16-bit accumulator value that drives led[15:0] and shows it on the 4-digit, common-anode 7-segment display.
- Decimal mode uses a sequential double-dabble conversion; hex mode shows raw nibbles.
- Scans the four digits by time multiplexing, with leading-zero blanking and overflow indication.

Parameters:
- REFRESH_DIV, 100000: clk cycles each digit stays lit (1 ms at 100 MHz, 250 Hz frame).
- CNT_W, $clog2(REFRESH_DIV): width of the refresh counter.

Ports:
- clk  in  1  system clock.
- btnC  in  1  reset. Synchronous, active-high.
- value  in  16  unsigned value to display (accumulator output).
- hex_mode  in  1  1 = hexadecimal display, 0 = decimal display.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- anode  out  4  digit enables, active-low one-hot; anode[0] is the rightmost digit.
- dp  out  1  decimal point, active-low; held at 1 (off).
- busy  out  1  high while a conversion is in progress.

Behaviour:
- Reset (btnC=1 at a clk edge), all outputs registered:
  - seg=7'h7F, anode=4'hF, dp=1, busy=0.
  - Digit registers = 0, scan index = 0, refresh counter = 0.
  - FSM = IDLE; a conversion is forced on the first IDLE cycle after reset.
- FSM states:
  - IDLE: each cycle compare {hex_mode,value} with the latched {src_hex,src_val}. If they differ, or the force flag is set, latch both and go to SHIFT; busy=1 from the next cycle.
  - SHIFT: exactly 16 cycles. Each cycle, add 3 to every BCD nibble that is >=5, then shift {bcd[15:0],bin[15:0]} left by 1.
  - COMMIT: 1 cycle, then return to IDLE and set busy=0.
- COMMIT updates the displayed digit registers:
  - src_hex=1: digits = src_val nibbles; no blanking.
  - src_hex=0 and src_val > 9999: all four digits = DASH.
  - src_hex=0 otherwise: digits = BCD result, with leading zeros blanked. Digit0 is never blanked, so value 0 shows "0".
- Latency:
  - Input change to new digits in the registers: at most 18 cycles (1 IDLE detect + 16 SHIFT + 1 COMMIT).
  - New digits reach seg when that digit is next scanned.
- Changes to value or hex_mode during SHIFT are ignored. They are caught by the IDLE compare after COMMIT. The display never shows a torn or partial result.
- Scan:
  - Refresh counter counts 0..REFRESH_DIV-1. At the terminal count it wraps to 0 and the scan index increments mod 4 (3 -> 0).
  - anode = ~(4'b0001 << idx); seg = decode(digit[idx]), both registered one cycle behind idx.
- Decoder (active-low codes):
  - 0..F use the standard codes: 0=7'h40, 1=7'h79, 2=7'h24, ..., b=7'h03, E=7'h06, F=7'h0E.
  - BLANK=7'h7F, DASH=7'h3F.
- Reset mid-conversion: conversion is aborted and busy=0. Digits are cleared, then the forced conversion restarts.
- The scan runs independently of the FSM; there are no stalls between them.

Decomposition:
- Shared package seg7_pkg holds:
  - the FSM state enum (IDLE, SHIFT, COMMIT);
  - the 5-bit digit code type (0-15, BLANK=16, DASH=17);
  - the segment constants;
  - the decode function;
  - the DEC_MAX=9999 constant.
- Sub-module bin16_to_bcd contains the sequential double-dabble engine.
  - Ports: clk, btnC, start, bin[15:0], busy, done, bcd[15:0].
  - It holds the SHIFT iteration count.
- The top-level module owns the change detect, commit/blanking logic, scan counter and output registers.

Test Plan (REFRESH_DIV=4):
- Reset: hold btnC for 3 cycles -> seg=7'h7F, anode=4'hF, dp=1, busy=0. After release with value=0: busy pulses for 17 cycles, then anode=4'b1110 with seg=7'h40 and the other three digits blank (7'h7F).
- value=12, hex_mode=0 -> busy clears within 18 cycles. Across one frame:
  - anode 1110: seg=7'h24 ("2");
  - anode 1101: seg=7'h79 ("1");
  - anode 1011 and 0111: seg=7'h7F.
- value changes 12->22 on the 5th SHIFT cycle -> a first commit shows 12, and a second commit within a further 18 cycles shows 22 (digit0 seg=7'h24, digit1 seg=7'h24).
- value=10000, hex_mode=0 -> all four digits show seg=7'h3F. Then value=9999 -> every digit shows seg=7'h10.
- hex_mode=1, value=16'hBEEF -> digits 3..0 show 7'h03, 7'h06, 7'h06, 7'h0E. value=16'h000C -> leading digits show 7'h40, not blank.
- Scan and mid-conversion reset:
  - anode steps 1110->1101->1011->0111->1110, each held exactly 4 cycles.
  - btnC asserted in the middle of SHIFT -> next cycle busy=0 and anode=4'hF; a clean restart follows.
